// File: rtl/spi_pkg_reader_pkg.sv
// Shared definitions for the SPI package reader: one-hot FSM encoding and
// default sizing for a full DAQ image package.
package spi_pkg_defs;

  typedef enum logic [4:0] {
    IDLE  = 5'b00001,
    SETUP = 5'b00010,
    SHIFT = 5'b00100,
    HOLD  = 5'b01000,
    DONE  = 5'b10000
  } state_e;

  localparam int DEF_PACKAGE_SIZE = 4864;
  localparam int DEF_CNT_W        = 14;
  localparam int DEF_SCK_HALF     = 4;
  localparam int DEF_CS_SETUP     = 2;
  localparam int DEF_CS_HOLD      = 2;

endpackage

// File: rtl/spi_sck_gen.sv
// SPI clock generator: sck toggles every SCK_HALF cycles while active, idles low.
// Strobes are combinational and mark the sys_clk edge at which sck will change.
module spi_sck_gen #(
  parameter int SCK_HALF = 4
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic active,
  output logic sck,
  output logic rise_stb,
  output logic fall_stb
);

  localparam int HC_W = (SCK_HALF > 1) ? $clog2(SCK_HALF) : 1;

  logic [HC_W-1:0] hcnt;
  logic            wrap;

  assign wrap     = active && (hcnt == HC_W'(SCK_HALF - 1));
  assign rise_stb = wrap && !sck;
  assign fall_stb = wrap && sck;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      hcnt <= '0;
      sck  <= 1'b0;
    end else if (!active) begin
      hcnt <= '0;
      sck  <= 1'b0;
    end else if (wrap) begin
      hcnt <= '0;
      sck  <= ~sck;
    end else begin
      hcnt <= hcnt + 1'b1;
    end
  end

endmodule

// File: rtl/spi_pkg_reader.sv
// SPI mode-0 master that drains one package from the DAQ slave per interrupt
// edge, holding cs_n low for the whole package and strobing out each byte.
module spi_pkg_reader
  import spi_pkg_defs::*;
#(
  parameter int PACKAGE_SIZE = DEF_PACKAGE_SIZE,
  parameter int CNT_W        = DEF_CNT_W,
  parameter int SCK_HALF     = DEF_SCK_HALF,
  parameter int CS_SETUP     = DEF_CS_SETUP,
  parameter int CS_HOLD      = DEF_CS_HOLD
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             enable,
  input  logic             intr_in,
  input  logic             miso,
  output logic             sck,
  output logic             cs_n,
  output logic [7:0]       rx_data,
  output logic             rx_valid,
  output logic             pkg_done,
  output logic             busy,
  output logic [CNT_W-1:0] byte_cnt
);

  localparam int TMR_W = 4;

  state_e           state, state_nxt;
  logic [2:0]       intr_sync;
  logic             intr_edge;
  logic             pending;
  logic             start;
  logic [TMR_W-1:0] tmr;
  logic [2:0]       bit_cnt;
  logic [7:0]       shreg;
  logic             rise_stb, fall_stb;

  spi_sck_gen #(.SCK_HALF(SCK_HALF)) u_sck_gen (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .active    (state == SHIFT),
    .sck       (sck),
    .rise_stb  (rise_stb),
    .fall_stb  (fall_stb)
  );

  // intr_sync[1:0] synchronise, intr_sync[2] is the delayed copy for edge detect
  assign intr_edge = intr_sync[1] & ~intr_sync[2];

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      intr_sync <= '0;
      pending   <= 1'b0;
    end else begin
      intr_sync <= {intr_sync[1:0], intr_in};
      if (intr_edge)  pending <= 1'b1;
      else if (start) pending <= 1'b0;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) state <= IDLE;
    else            state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    unique case (state)
      IDLE:  if (pending && enable) begin
               state_nxt = SETUP;
               start     = 1'b1;
             end
      SETUP: if (tmr == TMR_W'(CS_SETUP - 1)) state_nxt = SHIFT;
      SHIFT: if (fall_stb && byte_cnt == CNT_W'(PACKAGE_SIZE)) state_nxt = HOLD;
      HOLD:  if (tmr == TMR_W'(CS_HOLD - 1)) state_nxt = DONE;
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign cs_n     = ~((state == SETUP) || (state == SHIFT) || (state == HOLD));
  assign pkg_done = (state == DONE);
  assign busy     = (state != IDLE);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      tmr      <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
      byte_cnt <= '0;
    end else begin
      rx_valid <= 1'b0;
      // shared dwell timer for SETUP and HOLD; restarts on every state change
      if ((state == SETUP || state == HOLD) && state_nxt == state) tmr <= tmr + 1'b1;
      else                                                          tmr <= '0;
      if (state == SETUP) begin
        byte_cnt <= '0;
        bit_cnt  <= '0;
      end else if (rise_stb) begin
        shreg   <= {shreg[6:0], miso};
        bit_cnt <= bit_cnt + 1'b1;
        if (bit_cnt == 3'd7) begin
          rx_data  <= {shreg[6:0], miso};
          rx_valid <= 1'b1;
          byte_cnt <= byte_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_pkg_reader.sv
// Directed bench for spi_pkg_reader: mode-0 slave model driven from a byte table,
// strobe/cs_n monitors, and immediate-assertion checks against hand-computed values.
module tb_spi_pkg_reader;

  localparam int PKG = 16;
  localparam int CW  = 5;
  localparam int PKG_LOW = 2 + PKG * 64 + 2;   // cs_n low cycles per package
  localparam int PKG_T   = PKG_LOW + 1;        // including DONE

  logic          sys_clk = 1'b0;
  logic          sys_rst_n = 1'b0;
  logic          enable = 1'b1;
  logic          intr_in = 1'b0;
  logic          miso = 1'b0;
  logic          sck, cs_n, rx_valid, pkg_done, busy;
  logic [7:0]    rx_data;
  logic [CW-1:0] byte_cnt;

  int nchk = 0;
  int nerr = 0;

  spi_pkg_reader #(
    .PACKAGE_SIZE(PKG), .CNT_W(CW), .SCK_HALF(4), .CS_SETUP(2), .CS_HOLD(2)
  ) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .enable(enable), .intr_in(intr_in),
    .miso(miso), .sck(sck), .cs_n(cs_n), .rx_data(rx_data), .rx_valid(rx_valid),
    .pkg_done(pkg_done), .busy(busy), .byte_cnt(byte_cnt)
  );

  always #10 sys_clk = ~sys_clk;

  // slave: byte k of a package comes from slave_mem[k], MSB first, shifted on sck fall
  logic [7:0] slave_mem [0:PKG-1];
  int s_byte = 0;
  int s_bit  = 7;
  logic [7:0] s_cur;

  always @(negedge cs_n) begin
    s_byte = 0;
    s_bit  = 7;
    s_cur  = slave_mem[0];
    miso   = s_cur[7];
  end

  always @(negedge sck) begin
    if (!cs_n) begin
      if (s_bit == 0) begin
        s_bit  = 7;
        s_byte = (s_byte + 1) % PKG;
      end else begin
        s_bit = s_bit - 1;
      end
      s_cur = slave_mem[s_byte];
      miso  = s_cur[s_bit];
    end
  end

  // monitors
  logic [7:0] rx_log [0:255];
  int  rx_n = 0, done_cnt = 0;
  int  low_run = 0, last_low = 0, hi_run = 0, last_high = 0;
  int  sck_idle_bad = 0, miso_bad = 0;
  time miso_t = 0;

  always @(miso) miso_t = $time;
  always @(posedge sck) if ($time - miso_t < 20) miso_bad++;

  always @(negedge sys_clk) begin
    if (rx_valid) begin
      if (rx_n < 256) rx_log[rx_n] = rx_data;
      rx_n++;
    end
    if (pkg_done) done_cnt++;
    if (cs_n && sck) sck_idle_bad++;
    if (!cs_n) begin
      if (hi_run != 0) last_high = hi_run;
      hi_run = 0;
      low_run++;
    end else begin
      if (low_run != 0) last_low = low_run;
      low_run = 0;
      hi_run++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    assert (got === exp) else begin
      nerr++;
      $error("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic pulse_intr();
    intr_in = 1'b1;
    repeat (3) @(negedge sys_clk);
    intr_in = 1'b0;
  endtask

  task automatic wait_rx(input int target, input string tag);
    int budget = 3 * PKG_T;
    while (rx_n < target && budget > 0) begin
      @(negedge sys_clk);
      budget--;
    end
    chk(tag, 32'(rx_n >= target), 32'd1);
  endtask

  task automatic wait_done(input int target, input string tag);
    int budget = 3 * PKG_T;
    while (done_cnt < target && budget > 0) begin
      @(negedge sys_clk);
      budget--;
    end
    chk(tag, 32'(done_cnt >= target), 32'd1);
  endtask

  int base_rx, base_done, lat;

  initial begin
    for (int k = 0; k < PKG; k++) slave_mem[k] = 8'(k);
    repeat (3) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    @(negedge sys_clk);

    // reset state
    chk("rst_sck", 32'(sck), 32'd0);
    chk("rst_cs_n", 32'(cs_n), 32'd1);
    chk("rst_rx_data", 32'(rx_data), 32'd0);
    chk("rst_rx_valid", 32'(rx_valid), 32'd0);
    chk("rst_pkg_done", 32'(pkg_done), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_byte_cnt", 32'(byte_cnt), 32'd0);

    // 1) one package of an incrementing pattern
    base_rx = rx_n; base_done = done_cnt;
    pulse_intr();
    wait_done(base_done + 1, "t1_done_timeout");
    @(negedge sys_clk);
    chk("t1_nbytes", 32'(rx_n - base_rx), 32'(PKG));
    for (int k = 0; k < PKG; k++) chk($sformatf("t1_byte%0d", k), 32'(rx_log[base_rx + k]), 32'(k));
    chk("t1_cs_low", 32'(last_low), 32'(PKG_LOW));
    chk("t1_byte_cnt", 32'(byte_cnt), 32'(PKG));
    repeat (200) @(negedge sys_clk);
    chk("t1_one_done", 32'(done_cnt - base_done), 32'd1);
    chk("t1_idle_busy", 32'(busy), 32'd0);
    chk("t1_byte_cnt_hold", 32'(byte_cnt), 32'(PKG));

    // 2) bit order
    slave_mem[0] = 8'hA5; slave_mem[1] = 8'h3C;
    base_rx = rx_n; base_done = done_cnt;
    pulse_intr();
    wait_done(base_done + 1, "t2_done_timeout");
    chk("t2_byte0", 32'(rx_log[base_rx]), 32'h0A5);
    chk("t2_byte1", 32'(rx_log[base_rx + 1]), 32'h03C);
    chk("t2_byte2", 32'(rx_log[base_rx + 2]), 32'h002);
    chk("t2_sck_idle_low", 32'(sck_idle_bad), 32'd0);
    chk("t2_miso_stable", 32'(miso_bad), 32'd0);
    slave_mem[0] = 8'h00; slave_mem[1] = 8'h01;
    repeat (20) @(negedge sys_clk);

    // 3) second edge mid-package is remembered
    base_rx = rx_n; base_done = done_cnt;
    pulse_intr();
    wait_rx(base_rx + 5, "t3_rx5_timeout");
    pulse_intr();
    wait_done(base_done + 2, "t3_done2_timeout");
    chk("t3_gap_high", 32'(last_high), 32'd2);
    chk("t3_nbytes", 32'(rx_n - base_rx), 32'(2 * PKG));
    chk("t3_pkg2_byte7", 32'(rx_log[base_rx + PKG + 7]), 32'd7);
    repeat (100) @(negedge sys_clk);
    chk("t3_no_third", 32'(done_cnt - base_done), 32'd2);

    // 4) enable dropped mid-package with an edge pending
    base_done = done_cnt; base_rx = rx_n;
    pulse_intr();
    wait_rx(base_rx + 8, "t4_rx8_timeout");
    enable = 1'b0;
    pulse_intr();
    wait_done(base_done + 1, "t4_done_timeout");
    repeat (100) @(negedge sys_clk);
    chk("t4_held_cs_n", 32'(cs_n), 32'd1);
    chk("t4_held_done", 32'(done_cnt - base_done), 32'd1);
    enable = 1'b1;
    lat = 0;
    while (cs_n && lat < 3) begin
      @(negedge sys_clk);
      lat++;
    end
    chk("t4_setup_lat", 32'(lat), 32'd1);
    wait_done(base_done + 2, "t4_done2_timeout");
    repeat (20) @(negedge sys_clk);

    // 5) reset mid-byte
    base_rx = rx_n;
    pulse_intr();
    wait_rx(base_rx + 3, "t5_rx3_timeout");
    repeat (36) @(negedge sys_clk);
    base_rx = rx_n; base_done = done_cnt;
    chk("t5_pre_cs_n", 32'(cs_n), 32'd0);
    sys_rst_n = 1'b0;
    #1;
    chk("t5_async_cs_n", 32'(cs_n), 32'd1);
    chk("t5_async_sck", 32'(sck), 32'd0);
    repeat (3) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    repeat (200) @(negedge sys_clk);
    chk("t5_no_rx", 32'(rx_n - base_rx), 32'd0);
    chk("t5_no_done", 32'(done_cnt - base_done), 32'd0);
    chk("t5_idle_cs_n", 32'(cs_n), 32'd1);
    chk("t5_byte_cnt", 32'(byte_cnt), 32'd0);
    chk("t5_rx_data", 32'(rx_data), 32'd0);

    // 6) level-held interrupt reads exactly one package
    base_rx = rx_n; base_done = done_cnt;
    intr_in = 1'b1;
    repeat (3 * PKG_T + 50) @(negedge sys_clk);
    intr_in = 1'b0;
    repeat (50) @(negedge sys_clk);
    chk("t6_one_pkg", 32'(done_cnt - base_done), 32'd1);
    chk("t6_nbytes", 32'(rx_n - base_rx), 32'(PKG));
    chk("t6_idle", 32'(busy), 32'd0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
